// File: rtl/mdu_pkg.sv
// Shared types for the sequential RV32M multiply/divide unit.
package mdu_pkg;

  localparam logic [6:0] MDU_FUNCT7 = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_dec.sv
// funct3 decoder: operation class and operand signedness.
module mdu_dec
  import mdu_pkg::*;
(
  input  logic [2:0] funct3,
  output mdu_op_e    op,
  output logic       is_div,
  output logic       is_rem,
  output logic       is_high,
  output logic       a_signed,
  output logic       b_signed
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    op       = mdu_op_e'(funct3);
    is_div   = funct3[2];
    is_rem   = funct3[2] & funct3[1];
    is_high  = ~funct3[2] & (funct3[1:0] != 2'b00);
    a_signed = 1'b0;
    b_signed = 1'b0;
    unique case (op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      OP_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_seq.sv
// Sequential RV32M multiply/divide unit: one radix-2 step per cycle on operand
// magnitudes, sign fix-up on the way out, fast path for divide-by-zero/overflow.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int AW = 2 * XLEN + 1;

  mdu_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [XLEN-1:0] bmag_q, bmag_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            is_div_q, is_div_d, is_rem_q, is_rem_d, is_high_q, is_high_d;
  logic            neg_q, neg_d, rneg_q, rneg_d;

  mdu_op_e op;
  logic    dec_div, dec_rem, dec_high, a_signed, b_signed;

  mdu_dec u_dec (
    .funct3  (funct3),
    .op      (op),
    .is_div  (dec_div),
    .is_rem  (dec_rem),
    .is_high (dec_high),
    .a_signed(a_signed),
    .b_signed(b_signed)
  );

  logic            accept, a_neg, b_neg, div_zero, div_ovf, fast;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;

  assign accept   = start & ~busy & ~kill;
  assign a_neg    = a_signed & srca[XLEN-1];
  assign b_neg    = b_signed & srcb[XLEN-1];
  assign a_mag    = a_neg ? -srca : srca;
  assign b_mag    = b_neg ? -srcb : srcb;
  assign div_zero = dec_div & (srcb == '0);
  assign div_ovf  = (op == OP_DIV || op == OP_REM) &&
                    (srca == {1'b1, {(XLEN-1){1'b0}}}) && (&srcb);
  assign fast     = div_zero | div_ovf;
  assign fast_res = div_zero ? (dec_rem ? srca : '1) : (dec_rem ? '0 : srca);

  // Shared adder: multiply adds b to the high half; divide subtracts b from the
  // partial remainder shifted left by one.
  logic [XLEN:0] add_a, add_b, sum, mul_hi;
  logic [AW-1:0] acc_step;

  assign add_a = is_div_q ? acc_q[2*XLEN-1:XLEN-1] : acc_q[2*XLEN:XLEN];
  assign add_b = {1'b0, bmag_q};
  assign sum   = add_a + (add_b ^ {(XLEN+1){is_div_q}}) + {{XLEN{1'b0}}, is_div_q};
  assign mul_hi = acc_q[0] ? sum : acc_q[2*XLEN:XLEN];

  always_comb begin
    if (is_div_q) begin
      acc_step = sum[XLEN] ? {add_a, acc_q[XLEN-2:0], 1'b0}
                           : {sum,   acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_step = {1'b0, mul_hi, acc_q[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo, rem, calc_res;

  assign prod_s = neg_q ? -acc_step[2*XLEN-1:0] : acc_step[2*XLEN-1:0];
  assign quo    = acc_step[XLEN-1:0];
  assign rem    = acc_step[2*XLEN-1:XLEN];
  assign calc_res = is_div_q ? (is_rem_q ? (rneg_q ? -rem : rem) : (neg_q ? -quo : quo))
                             : (is_high_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0]);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      bmag_q    <= '0;
      result_q  <= '0;
      is_div_q  <= 1'b0;
      is_rem_q  <= 1'b0;
      is_high_q <= 1'b0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      bmag_q    <= bmag_d;
      result_q  <= result_d;
      is_div_q  <= is_div_d;
      is_rem_q  <= is_rem_d;
      is_high_q <= is_high_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start) state_d = fast ? FIN : CALC;
        CALC:    if (cnt_q == CNT_W'(1)) state_d = FIN;
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    bmag_d    = bmag_q;
    result_d  = result_q;
    is_div_d  = is_div_q;
    is_rem_d  = is_rem_q;
    is_high_d = is_high_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    if (accept) begin
      cnt_d     = CNT_W'(XLEN);
      acc_d     = {{(XLEN+1){1'b0}}, a_mag};
      bmag_d    = b_mag;
      is_div_d  = dec_div;
      is_rem_d  = dec_rem;
      is_high_d = dec_high;
      neg_d     = a_neg ^ b_neg;
      rneg_d    = a_neg;
      if (fast) result_d = fast_res;
    end else if (state_q == CALC && !kill) begin
      acc_d = acc_step;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) result_d = calc_res;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == FIN);
  assign result = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: stimulus pushes expected result and done cycle,
// a monitor pops on every done pulse.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        reset, start, kill;
  logic [2:0]  funct3;
  logic [31:0] srca, srcb;
  logic        busy, done;
  logic [31:0] result;

  mdu_seq #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .kill  (kill),
    .funct3(funct3),
    .srca  (srca),
    .srcb  (srcb),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_fail = 0;
  logic [31:0] last_res = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RISC-V M-extension semantics from plain 64-bit and integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] sa, sb, za, zb, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    za = {32'b0, a};
    zb = {32'b0, b};
    ia = a;
    ib = b;
    case (f)
      3'b000: begin p = za * zb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * zb; return p[63:32]; end
      3'b011: begin p = za * zb; return p[63:32]; end
      3'b100: begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'b101: return (b == 0) ? '1 : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", {31'b0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result", result, e.res);
        check("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Called at a negedge with the unit idle; returns at the following negedge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit expect_done);
    bit   fast;
    exp_t e;
    fast = f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    start  = 1'b1;
    funct3 = f;
    srca   = a;
    srcb   = b;
    if (expect_done) begin
      e.res = ref_model(f, a, b);
      e.cyc = cyc + (fast ? 1 : 33);
      sb_q.push_back(e);
      last_res = e.res;
    end
    @(negedge clk);
    start  = 1'b0;
    funct3 = 3'($urandom_range(7));
    srca   = $urandom;
    srcb   = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  logic [2:0]  d_f[11] = '{3'b001, 3'b011, 3'b010, 3'b101, 3'b111, 3'b100, 3'b110,
                           3'b100, 3'b110, 3'b101, 3'b111};
  logic [31:0] d_a[11] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5,
                           32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                           32'd100, 32'd100};
  logic [31:0] d_b[11] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0,
                           32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd7, 32'd7};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    kill   = 1'b0;
    funct3 = '0;
    srca   = '0;
    srcb   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);

    // MUL 7 x -3 with busy profile
    check("busy_before_accept", {31'b0, busy}, 32'd0);
    issue(3'b000, 32'd7, 32'hFFFF_FFFD, 1'b1);
    check("busy_after_accept", {31'b0, busy}, 32'd1);
    wait_idle();

    // Directed high-half multiplies, divide-by-zero, overflow and signed divide
    for (int i = 0; i < 11; i++) begin
      issue(d_f[i], d_a[i], d_b[i], 1'b1);
      wait_idle();
    end

    // start while busy is ignored
    issue(3'b000, $urandom, $urandom, 1'b1);
    repeat (9) @(negedge clk);
    start = 1'b1;
    srca  = $urandom;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // start during the done cycle is ignored
    issue(3'b101, $urandom, 32'($urandom_range(255, 1)), 1'b1);
    for (int n = 0; n < 60 && !done; n++) @(negedge clk);
    start  = 1'b1;
    funct3 = 3'b000;
    @(negedge clk);
    start = 1'b0;
    check("fin_start_ignored", {31'b0, busy}, 32'd0);

    // kill together with start: no accept
    kill  = 1'b1;
    start = 1'b1;
    @(negedge clk);
    kill  = 1'b0;
    start = 1'b0;
    check("kill_start_no_accept", {31'b0, busy}, 32'd0);

    // kill mid-divide, then reset mid-multiply
    issue(3'b100, 32'd1000, 32'd3, 1'b0);
    repeat (14) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy", {31'b0, busy}, 32'd0);
    check("kill_result_held", result, last_res);
    issue(3'b000, 32'd12345, 32'd678, 1'b0);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_res = '0;
    check("reset_mid_result", result, 32'd0);
    check("reset_mid_busy", {31'b0, busy}, 32'd0);
    repeat (40) @(negedge clk);

    // Randomized operations with biased corner operands
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      int          sel;
      f   = 3'($urandom_range(7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(7);
      if (sel == 0) b = '0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(15, 1));
      else if (sel == 3) b = -32'($urandom_range(15, 1));
      issue(f, a, b, 1'b1);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    check("missing_done", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
